master_port: RTL
================

# master_port

Bit-serial initiator for the system bus. It accepts one parallel read or write request from a local master, sends the request onto the serial bus as a mode bit plus MSB-first address and write data, and for reads collects the MSB-first response bits. It then returns a single-cycle response to the local side. It sits between a local master (CPU or test driver) and the bus interconnect, and is the counterpart of the bus slave ports.

## Interface
- ADDR_WIDTH, 16, address bits serialized per transaction
- DATA_WIDTH, 8, data bits per transfer
- TIMEOUT, 64, max cycles without a handshake before abort (>=2)

- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  local request present
- req_ready  out  1  block can accept a request
- req_mode  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  transaction aborted by timeout, valid with rsp_valid
- mode  out  1  bus mode bit, held for the whole transaction
- wr_bus  out  1  serial master-to-slave data
- master_valid  out  1  master driving a valid bit on wr_bus
- master_ready  out  1  master can take a bit on rd_bus
- rd_bus  in  1  serial slave-to-master data
- slave_ready  in  1  slave accepts the current wr_bus bit
- slave_valid  in  1  slave driving a valid bit on rd_bus

## Operation
- FSM states: IDLE, ADDR, DATA, RDATA, DONE.
- **IDLE**
  - req_ready=1.
  - On req_valid, latch mode, addr and wdata into shift registers, clear the bit counter and timeout counter, then go to ADDR.
- **ADDR**
  - master_valid=1; wr_bus = current address MSB.
  - A bit is transferred in any cycle with master_valid && slave_ready. On transfer: shift left, increment the counter, clear the timeout counter.
  - After ADDR_WIDTH transfers, go to DATA if mode=1, or RDATA if mode=0. Clear the counter.
- **DATA**
  - Same handshake as ADDR, shifting out wdata MSB-first.
  - After DATA_WIDTH transfers, go to DONE.
- **RDATA**
  - master_valid=0, master_ready=1.
  - Each cycle with slave_valid && master_ready: shift rd_bus into the LSB of the receive register and clear the timeout counter.
  - After DATA_WIDTH bits, go to DONE.
- **Timeout**
  - In ADDR, DATA or RDATA, the timeout counter increments on every cycle with no handshake.
  - When it reaches TIMEOUT-1 with no handshake that cycle, set the error flag and go to DONE.
  - Partial read data is discarded.
- **DONE**
  - rsp_valid=1 for exactly one cycle, with rsp_rdata (reads only) and rsp_err. Then go to IDLE.
  - master_valid and master_ready are 0, which guarantees at least one bus-idle cycle between transactions.
- mode output = latched mode in ADDR/DATA/RDATA, 0 otherwise. wr_bus = 0 when master_valid=0.
- Counter width: $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1). Timeout counter width: $clog2(TIMEOUT).
- A request presented while not in IDLE is not accepted and must be held by the local side.

## Timing
- Reset: state IDLE; req_ready=1; all other outputs 0, including rsp_rdata.
- Reset mid-transaction: next cycle master_valid=0 and master_ready=0. No rsp_valid is produced for the aborted transaction.
- Request accepted at cycle 0 → master_valid rises at cycle 1 with address MSB on wr_bus.
- Write with slave_ready held high: address bits at cycles 1..ADDR_WIDTH, data bits at ADDR_WIDTH+1..ADDR_WIDTH+DATA_WIDTH, rsp_valid at ADDR_WIDTH+DATA_WIDTH+1 (cycle 25 for defaults).
- Read: RDATA entered at cycle ADDR_WIDTH+1. If the first slave_valid bit is at cycle k, bits are captured at k..k+DATA_WIDTH-1 (when continuous) and rsp_valid is at k+DATA_WIDTH.
- wr_bus is stable while master_valid=1 && slave_ready=0.
- Earliest next acceptance: cycle after DONE.

## Structure
- Shared package bus_pkg holds:
  - the master FSM state enum;
  - MODE_READ=0 and MODE_WRITE=1 constants, also usable by the slave ports.
- One sub-module, bus_timeout_ctr, parameterized by TIMEOUT, with inputs clr and en and output expired. The shift and receive registers stay inline.

## Test plan
- Write with slave_ready=1: addr 0x0025, wdata 0xA5 → wr_bus serial stream 0000000000100101_10100101 on cycles 1..24, mode=1 throughout, rsp_valid at cycle 25 with rsp_err=0.
- Write to a slave port at addr 0x0003 with 0x3C, then read addr 0x0003 → rsp_rdata=0x3C, rsp_err=0.
- Backpressure: slave_ready toggles 1,0,0,1... during address → wr_bus holds each bit while stalled; total address phase = 16 handshakes; correct address decoded.
- Read timeout: slave_valid never asserted, TIMEOUT=8 → rsp_valid with rsp_err=1 and rsp_rdata=0, occurring 8 cycles after entering RDATA.
- Reset asserted at the 5th address bit → master_valid=0 the next cycle, no rsp_valid; a fresh request then completes normally.
- Back-to-back requests with req_valid held high → req_ready low during the transaction, at least one cycle with master_valid=0 between transactions.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial system bus.
// Contents:
//   mst_state_e - state encoding of the master port FSM
//   MODE_READ / MODE_WRITE - values of the bus mode bit, shared with the slave ports
//   max_int - helper for sizing counters from two widths
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } mst_state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Handshake watchdog for the serial bus.
// Counts cycles without a handshake and flags when TIMEOUT-1 is reached.
// Ports:
//   clk, rstn - clock, synchronous active-low reset
//   clr       - restart the count (handshake seen or not in a bus phase)
//   en        - count this cycle (bus phase with no handshake)
//   expired   - count has reached TIMEOUT-1
module bus_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired = (cnt_q == TW'(TIMEOUT - 1));

    // Saturates at TIMEOUT-1; the FSM leaves the bus phase on that cycle anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/master_port.sv
// Bit-serial bus initiator.
// Takes one parallel read/write request from the local master, shifts the
// address (and write data) MSB-first onto wr_bus, collects read data MSB-first
// from rd_bus, and returns a one-cycle response.
// Ports:
//   clk, rstn                      - clock, synchronous active-low reset
//   req_valid/req_ready            - local request handshake
//   req_mode/req_addr/req_wdata    - request payload (mode 1 = write)
//   rsp_valid/rsp_rdata/rsp_err    - one-cycle completion, read data, timeout flag
//   mode                           - bus mode bit, held during the transaction
//   wr_bus/master_valid/slave_ready - master-to-slave serial channel
//   rd_bus/slave_valid/master_ready - slave-to-master serial channel
//
// state | meaning
// IDLE  | waiting for a local request, req_ready high
// ADDR  | shifting out address bits
// DATA  | shifting out write data bits
// RDATA | collecting read data bits
// DONE  | one-cycle response, bus idle
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mode,
    output logic                  wr_bus,
    output logic                  master_valid,
    output logic                  master_ready,
    input  logic                  rd_bus,
    input  logic                  slave_ready,
    input  logic                  slave_valid
);

    localparam int CW = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);

    mst_state_e state_q, state_d;

    logic                  mode_q,  mode_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic                  err_q,   err_d;

    logic hs;
    logic active;
    logic tmo_expired;
    logic tmo_hit;
    logic last_addr;
    logic last_data;

    // Only one of the two channels can be live in any state, so a single
    // handshake strobe serves ADDR, DATA and RDATA.
    assign hs = (master_valid && slave_ready) || (master_ready && slave_valid);

    assign active = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RDATA);

    // A handshake in the expiring cycle still counts; only a silent cycle aborts.
    assign tmo_hit = active && !hs && tmo_expired;

    assign last_addr = (cnt_q == CW'(ADDR_WIDTH - 1));
    assign last_data = (cnt_q == CW'(DATA_WIDTH - 1));

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (!active || hs),
        .en      (active && !hs),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (tmo_hit) begin
                    state_d = ST_DONE;
                end else if (hs && last_addr) begin
                    state_d = (mode_q == MODE_WRITE) ? ST_DATA : ST_RDATA;
                end
            end
            ST_DATA, ST_RDATA: begin
                if (tmo_hit || (hs && last_data)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mode_d  = req_mode;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_ADDR: begin
                if (tmo_hit) begin
                    err_d = 1'b1;
                end else if (hs) begin
                    addr_d = {addr_q[ADDR_WIDTH-2:0], 1'b0};
                    cnt_d  = last_addr ? '0 : cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tmo_hit) begin
                    err_d = 1'b1;
                end else if (hs) begin
                    wdata_d = {wdata_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_d   = last_data ? '0 : cnt_q + 1'b1;
                end
            end
            ST_RDATA: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (hs) begin
                    rdata_d = {rdata_q[DATA_WIDTH-2:0], rd_bus};
                    cnt_d   = last_data ? '0 : cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        wr_bus       = 1'b0;
        mode         = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_ADDR: begin
                master_valid = 1'b1;
                wr_bus       = addr_q[ADDR_WIDTH-1];
                mode         = mode_q;
            end
            ST_DATA: begin
                master_valid = 1'b1;
                wr_bus       = wdata_q[DATA_WIDTH-1];
                mode         = mode_q;
            end
            ST_RDATA: begin
                master_ready = 1'b1;
                mode         = mode_q;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (mode_q == MODE_READ && !err_q) rsp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule
